// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared widths, FSM encoding and burst-size helper for the AXI write controller
package axi_wr_pkg;
  localparam int AXI_DATA_W     = 64;
  localparam int AXI_ADDR_W     = 30;
  localparam int BYTES_PER_BEAT = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BUSY = 2'd2} wr_state_e;
  // (len+1)*8 in 31 bits so a 256-beat burst never truncates
  function automatic logic [AXI_ADDR_W:0] burst_bytes(input logic [7:0] len);
    return (31'(len) + 31'd1) * 31'(BYTES_PER_BEAT);
  endfunction
endpackage

// File: rtl/axi_wr_ctrl_if.sv
// axi_wr_ctrl_if: command/data link between the write controller and the downstream AXI write master
//   master modport (controller): drives wr_start, wr_addr, wr_len, wr_data; receives wr_ready, wr_done, m_axi_w_handshake
//   slave modport (AXI write master): the reverse directions
interface axi_wr_ctrl_if;
  import axi_wr_pkg::*;
  logic                  wr_start;
  logic [AXI_ADDR_W-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic [AXI_DATA_W-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  m_axi_w_handshake;
  modport master (output wr_start, wr_addr, wr_len, wr_data, input wr_ready, wr_done, m_axi_w_handshake);
  modport slave  (input wr_start, wr_addr, wr_len, wr_data, output wr_ready, wr_done, m_axi_w_handshake);
endinterface

// File: rtl/wr_ctrl_fifo.sv
// wr_ctrl_fifo: first-word-fall-through write FIFO, 2^FIFO_AW x 64-bit
//   push_i/din_i write side, pop_i read side (ignored when empty), dout_o = head entry,
//   full_o and count_o derived from the registered occupancy
module wr_ctrl_fifo import axi_wr_pkg::*; #(
  parameter int FIFO_AW = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [AXI_DATA_W-1:0] din_i,
  output logic [AXI_DATA_W-1:0] dout_o,
  output logic                  full_o,
  output logic [FIFO_AW:0]      count_o
);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);
  logic [AXI_DATA_W-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign full_o  = count_q == DEPTH;
  // a push alongside a pop at full frees the slot in the same cycle, so occupancy holds
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + FIFO_AW'(do_push);
      rd_ptr_q <= rd_ptr_q + FIFO_AW'(do_pop);
      count_q  <= count_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
endmodule

// File: rtl/axi_wr_ctrl.sv
// axi_wr_ctrl: buffers user write words and issues AXI write bursts over a wrapping address region
//   clk/rst_n (async active-low), user_wr_en/user_wr_data/user_wr_full user side,
//   wr_beg_addr/wr_end_addr/wr_burst_len/wr_addr_clr configuration, axi (master modport) downstream link,
//   wr_ovf_cnt dropped-word count, live only when AXI_WR_CTRL_OVF_CNT_EN is defined
module axi_wr_ctrl import axi_wr_pkg::*; #(
  parameter int FIFO_AW = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  user_wr_en,
  input  logic [AXI_DATA_W-1:0] user_wr_data,
  output logic                  user_wr_full,
  input  logic [AXI_ADDR_W-1:0] wr_beg_addr,
  input  logic [AXI_ADDR_W-1:0] wr_end_addr,
  input  logic [7:0]            wr_burst_len,
  input  logic                  wr_addr_clr,
  axi_wr_ctrl_if.master         axi,
  output logic [15:0]           wr_ovf_cnt
);
  wr_state_e state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic clr_pend_q, clr_pend_d;
  logic [FIFO_AW:0] fifo_count;
  logic [AXI_ADDR_W:0] bytes, next_addr;
  logic wrap;
  wr_ctrl_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (user_wr_en),
    .pop_i  (axi.m_axi_w_handshake),
    .din_i  (user_wr_data),
    .dout_o (axi.wr_data),
    .full_o (user_wr_full),
    .count_o(fifo_count)
  );
  assign bytes     = burst_bytes(len_q);
  assign next_addr = {1'b0, addr_q} + bytes;
  // wrap when the following burst would run past the inclusive end address
  assign wrap      = next_addr + bytes - 31'd1 > {1'b0, wr_end_addr};
  assign axi.wr_start = state_q == REQ;
  assign axi.wr_addr  = addr_q;
  assign axi.wr_len   = len_q;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    clr_pend_d = clr_pend_q;
    unique case (state_q)
      IDLE: begin
        if (wr_addr_clr) addr_d = wr_beg_addr;
        if (axi.wr_ready && 32'(fifo_count) >= 32'(wr_burst_len) + 32'd1) begin
          state_d = REQ;
          len_d   = wr_burst_len;
        end
      end
      REQ: begin
        state_d = BUSY;
        if (wr_addr_clr) clr_pend_d = 1'b1;
      end
      BUSY: begin
        if (axi.wr_done) begin
          state_d    = IDLE;
          addr_d     = (clr_pend_q || wr_addr_clr || wrap) ? wr_beg_addr : next_addr[AXI_ADDR_W-1:0];
          clr_pend_d = 1'b0;
        end else if (wr_addr_clr) clr_pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      clr_pend_q <= clr_pend_d;
    end
`ifdef AXI_WR_CTRL_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic drop;
  // at full only a push paired with a pop gets in
  assign drop = user_wr_en && user_wr_full && !axi.m_axi_w_handshake;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= '0;
    else if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
  assign wr_ovf_cnt = ovf_q;
`else
  assign wr_ovf_cnt = '0;
`endif
endmodule
